// File: rtl/pwm_capture.sv
// PWM input capture: recovers the duty word (high time) and rise-to-rise period
// of an external PWM line, with a timeout path for a static input level.
//
// state  | meaning
// IDLE   | synchroniser filling or line high; wait for a real low level
// ARMED  | line seen low; wait for the first rising edge to open a period
// MEAS   | counting high time and period; each rise publishes and restarts
module pwm_capture #(
   parameter int W       = 10,
   parameter int TIMEOUT = 2048
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           pwm_in,
   output logic [W-1:0]   data_out,
   output logic [W+1:0]   period_out,
   output logic           valid,
   output logic           timeout
);

   localparam int RW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [RW-1:0] RUN_LAST  = RW'(TIMEOUT - 1);
   localparam logic [RW-1:0] RUN_ONE   = RW'(1);
   localparam logic [W+1:0]  CNT_MAX   = '1;
   localparam logic [W+1:0]  CNT_ONE   = (W+2)'(1);
   localparam logic [W-1:0]  DATA_MAX  = '1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_MEAS  = 2'd2;

   logic          s1, s2, s3;
   logic [1:0]    sync_fill;
   logic [1:0]    state;
   logic [W+1:0]  hi_cnt;
   logic [W+1:0]  per_cnt;
   logic [RW-1:0] run_cnt;

   logic          rise;
   logic          level_change;
   logic          run_expired;
   logic          sync_primed;
   logic [W+1:0]  hi_next;
   logic [W+1:0]  per_next;
   logic [W-1:0]  hi_clamped;

   assign rise         = s2 & ~s3;
   assign level_change = s2 ^ s3;
   assign run_expired  = ~level_change & (run_cnt == RUN_LAST);

   // s2 only carries a real sample once two clocks have passed since reset;
   // without this, a line already high at reset release looks like a fresh rise.
   assign sync_primed  = sync_fill[1];

   assign hi_next    = (hi_cnt == CNT_MAX) ? hi_cnt : hi_cnt + CNT_ONE;
   assign per_next   = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_ONE;
   assign hi_clamped = (|hi_cnt[W+1:W]) ? DATA_MAX : hi_cnt[W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1        <= 1'b0;
         s2        <= 1'b0;
         s3        <= 1'b0;
         sync_fill <= 2'b00;
      end else begin
         s1        <= pwm_in;
         s2        <= s1;
         s3        <= s2;
         sync_fill <= {sync_fill[0], 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_cnt <= '0;
      end else if (level_change || run_expired) begin
         run_cnt <= '0;
      end else begin
         run_cnt <= run_cnt + RUN_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         hi_cnt     <= '0;
         per_cnt    <= '0;
         data_out   <= '0;
         period_out <= '0;
         valid      <= 1'b0;
         timeout    <= 1'b0;
      end else begin
         valid <= 1'b0;
         if (run_expired) begin
            data_out   <= s2 ? DATA_MAX : '0;
            period_out <= '0;
            timeout    <= 1'b1;
            valid      <= 1'b1;
            hi_cnt     <= '0;
            per_cnt    <= '0;
            state      <= s2 ? ST_IDLE : ST_ARMED;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (sync_primed && !s2) begin
                     state <= ST_ARMED;
                  end
               end
               ST_ARMED: begin
                  if (rise) begin
                     hi_cnt  <= CNT_ONE;
                     per_cnt <= CNT_ONE;
                     state   <= ST_MEAS;
                  end
               end
               ST_MEAS: begin
                  if (rise) begin
                     data_out   <= hi_clamped;
                     period_out <= per_cnt;
                     timeout    <= 1'b0;
                     valid      <= 1'b1;
                     hi_cnt     <= CNT_ONE;
                     per_cnt    <= CNT_ONE;
                  end else begin
                     per_cnt <= per_next;
                     if (s2) begin
                        hi_cnt <= hi_next;
                     end
                  end
               end
               default: begin
                  state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule
